// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline writeback and buffered long-latency results onto one
// registered register-file write port. Optional busy scoreboard under WB_SCOREBOARD_EN.
module wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    pipe_valid_i,
    input  logic [4:0]              pipe_rd_i,
    input  logic [XLEN-1:0]         pipe_data_i,
    input  logic                    lu_issue_i,
    input  logic [4:0]              lu_issue_rd_i,
    input  logic                    lu_valid_i,
    input  logic [4:0]              lu_rd_i,
    input  logic [XLEN-1:0]         lu_data_i,
    output logic                    lu_ready_o,
    output logic                    wb_we_o,
    output logic [4:0]              wb_rd_o,
    output logic [XLEN-1:0]         wb_data_o,
    output logic [31:0]             busy_o,
    output logic [$clog2(DEPTH):0]  fifo_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [4:0]      mem_rd_q   [DEPTH];
    logic [XLEN-1:0] mem_data_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;

    logic            wb_we_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;

    logic            lu_xfer, fifo_empty, push, pop, bypass;
    logic            sel_valid, sel_lu;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    assign lu_ready_o = (count_q != CW'(DEPTH));
    assign lu_xfer    = lu_valid_i && lu_ready_o;
    assign fifo_empty = (count_q == '0);

    // Pipeline first, then the FIFO head, then a same-cycle lu bypass.
    always_comb begin
        pop       = 1'b0;
        bypass    = 1'b0;
        sel_valid = 1'b0;
        sel_lu    = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (pipe_valid_i) begin
            sel_valid = 1'b1;
            sel_rd    = pipe_rd_i;
            sel_data  = pipe_data_i;
        end else if (!fifo_empty) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
            sel_lu    = 1'b1;
            sel_rd    = mem_rd_q[rd_ptr_q];
            sel_data  = mem_data_q[rd_ptr_q];
        end else if (lu_xfer) begin
            bypass    = 1'b1;
            sel_valid = 1'b1;
            sel_lu    = 1'b1;
            sel_rd    = lu_rd_i;
            sel_data  = lu_data_i;
        end
    end

    assign push = lu_xfer && !bypass;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            // Writes to x0 still consume their entry but never reach the register file.
            wb_we_q <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                wb_rd_q   <= sel_rd;
                wb_data_q <= sel_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_rd_q[wr_ptr_q]   <= lu_rd_i;
            mem_data_q[wr_ptr_q] <= lu_data_i;
        end
    end

    assign wb_we_o      = wb_we_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign fifo_count_o = count_q;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // Set is applied after clear so a same-cycle reissue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (sel_lu && sel_rd != 5'd0) busy_d[sel_rd] = 1'b0;
        if (lu_issue_i && lu_issue_rd_i != 5'd0) busy_d[lu_issue_rd_i] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
`else
    logic unused_issue;
    assign unused_issue = ^{lu_issue_i, lu_issue_rd_i, sel_lu};
    assign busy_o       = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DEPTH=4, XLEN=32).
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_issue;
    logic [4:0]  lu_issue_rd;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] busy;
    logic [2:0]  fifo_count;

    int passed = 0;
    int total  = 0;

`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    wb_arbiter #(.DEPTH(4), .XLEN(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pipe_valid_i (pipe_valid),
        .pipe_rd_i    (pipe_rd),
        .pipe_data_i  (pipe_data),
        .lu_issue_i   (lu_issue),
        .lu_issue_rd_i(lu_issue_rd),
        .lu_valid_i   (lu_valid),
        .lu_rd_i      (lu_rd),
        .lu_data_i    (lu_data),
        .lu_ready_o   (lu_ready),
        .wb_we_o      (wb_we),
        .wb_rd_o      (wb_rd),
        .wb_data_o    (wb_data),
        .busy_o       (busy),
        .fifo_count_o (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_busy(input logic [31:0] v);
        return SB ? v : 32'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
        lu_issue = 0; lu_issue_rd = 0; lu_valid = 0; lu_rd = 0; lu_data = 0;
        step();
        step();
        rst = 1'b0;
        total++; if (wb_we !== 1'b0) $display("FAIL reset_we got %0b want 0", wb_we); else passed++;
        total++; if (wb_rd !== 5'd0) $display("FAIL reset_rd got %0d want 0", wb_rd); else passed++;
        total++; if (wb_data !== 32'h0) $display("FAIL reset_data got %h want 0", wb_data); else passed++;
        total++; if (busy !== 32'h0) $display("FAIL reset_busy got %h want 0", busy); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else passed++;
        total++; if (lu_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", lu_ready); else passed++;
    endtask

    task automatic test_pipe();
        pipe_valid = 1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        step();
        pipe_valid = 0;
        total++; if (wb_we !== 1'b1) $display("FAIL pipe_we got %0b want 1", wb_we); else passed++;
        total++; if (wb_rd !== 5'd5) $display("FAIL pipe_rd got %0d want 5", wb_rd); else passed++;
        total++; if (wb_data !== 32'hDEADBEEF) $display("FAIL pipe_data got %h want deadbeef", wb_data); else passed++;
        total++; if (busy !== 32'h0) $display("FAIL pipe_busy got %h want 0", busy); else passed++;
        total++; if (lu_ready !== 1'b1) $display("FAIL pipe_ready got %0b want 1", lu_ready); else passed++;
        step();
        total++; if (wb_we !== 1'b0) $display("FAIL idle_we got %0b want 0", wb_we); else passed++;
        total++; if (wb_rd !== 5'd5) $display("FAIL idle_hold_rd got %0d want 5", wb_rd); else passed++;
    endtask

    task automatic test_bypass();
        lu_issue = 1; lu_issue_rd = 5'd7;
        step();
        lu_issue = 0;
        total++; if (busy !== exp_busy(32'h80)) $display("FAIL byp_busy_set got %h want %h", busy, exp_busy(32'h80)); else passed++;
        step();
        step();
        lu_valid = 1; lu_rd = 5'd7; lu_data = 32'h12345678;
        total++; if (lu_ready !== 1'b1) $display("FAIL byp_ready got %0b want 1", lu_ready); else passed++;
        step();
        lu_valid = 0;
        total++; if (wb_we !== 1'b1) $display("FAIL byp_we got %0b want 1", wb_we); else passed++;
        total++; if (wb_rd !== 5'd7) $display("FAIL byp_rd got %0d want 7", wb_rd); else passed++;
        total++; if (wb_data !== 32'h12345678) $display("FAIL byp_data got %h want 12345678", wb_data); else passed++;
        total++; if (busy !== 32'h0) $display("FAIL byp_busy_clr got %h want 0", busy); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL byp_count got %0d want 0", fifo_count); else passed++;
    endtask

    task automatic test_backpressure();
        int k = 0;
        logic rdy;
        int exp_cnt [5] = '{3, 3, 2, 1, 0};
        for (int c = 0; c < 10; c++) begin
            pipe_valid = 1; pipe_rd = 5'd1; pipe_data = 32'(c);
            lu_valid = (k < 5); lu_rd = 5'(10 + k); lu_data = 32'(8'hA0 + k);
            rdy = lu_ready;
            step();
            if (lu_valid && rdy) k++;
        end
        total++; if (k !== 4) $display("FAIL bp_accepted got %0d want 4", k); else passed++;
        total++; if (fifo_count !== 3'd4) $display("FAIL bp_count got %0d want 4", fifo_count); else passed++;
        total++; if (lu_ready !== 1'b0) $display("FAIL bp_ready got %0b want 0", lu_ready); else passed++;
        total++; if (wb_we !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'd9)
            $display("FAIL bp_pipe got we=%0b rd=%0d data=%h want 1/1/9", wb_we, wb_rd, wb_data);
        else passed++;
        for (int j = 0; j < 5; j++) begin
            pipe_valid = 0;
            lu_valid = (k < 5); lu_rd = 5'(10 + k); lu_data = 32'(8'hA0 + k);
            rdy = lu_ready;
            step();
            if (lu_valid && rdy) k++;
            total++; if (wb_we !== 1'b1 || wb_rd !== 5'(10 + j) || wb_data !== 32'(8'hA0 + j))
                $display("FAIL drain%0d got we=%0b rd=%0d data=%h want 1/%0d/%h", j, wb_we, wb_rd,
                         wb_data, 10 + j, 8'hA0 + j);
            else passed++;
            total++; if (fifo_count !== 3'(exp_cnt[j]))
                $display("FAIL drain%0d_count got %0d want %0d", j, fifo_count, exp_cnt[j]);
            else passed++;
        end
        lu_valid = 0;
        total++; if (k !== 5) $display("FAIL bp_fifth got %0d want 5", k); else passed++;
    endtask

    task automatic test_rd0();
        lu_valid = 1; lu_rd = 5'd0; lu_data = 32'h55;
        step();
        lu_valid = 0;
        total++; if (wb_we !== 1'b0) $display("FAIL rd0_byp_we got %0b want 0", wb_we); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL rd0_byp_count got %0d want 0", fifo_count); else passed++;
        pipe_valid = 1; pipe_rd = 5'd3; pipe_data = 32'h33;
        lu_valid = 1; lu_rd = 5'd0; lu_data = 32'h66;
        step();
        pipe_valid = 0; lu_valid = 0;
        total++; if (wb_we !== 1'b1 || wb_rd !== 5'd3) $display("FAIL rd0_pipe got we=%0b rd=%0d want 1/3", wb_we, wb_rd); else passed++;
        total++; if (fifo_count !== 3'd1) $display("FAIL rd0_push_count got %0d want 1", fifo_count); else passed++;
        step();
        total++; if (wb_we !== 1'b0) $display("FAIL rd0_pop_we got %0b want 0", wb_we); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL rd0_pop_count got %0d want 0", fifo_count); else passed++;
    endtask

    task automatic test_set_wins();
        lu_issue = 1; lu_issue_rd = 5'd9;
        step();
        total++; if (busy !== exp_busy(32'h200)) $display("FAIL sw_set got %h want %h", busy, exp_busy(32'h200)); else passed++;
        lu_valid = 1; lu_rd = 5'd9; lu_data = 32'h99;
        step();
        lu_issue = 0;
        total++; if (busy !== exp_busy(32'h200)) $display("FAIL sw_setwins got %h want %h", busy, exp_busy(32'h200)); else passed++;
        total++; if (wb_we !== 1'b1 || wb_rd !== 5'd9) $display("FAIL sw_wb got we=%0b rd=%0d want 1/9", wb_we, wb_rd); else passed++;
        step();
        lu_valid = 0;
        total++; if (busy !== 32'h0) $display("FAIL sw_clear got %h want 0", busy); else passed++;
    endtask

    task automatic test_async_reset();
        lu_issue = 1; lu_issue_rd = 5'd7;
        step();
        lu_issue_rd = 5'd9;
        step();
        lu_issue = 0;
        total++; if (busy !== exp_busy(32'h280)) $display("FAIL ar_busy got %h want %h", busy, exp_busy(32'h280)); else passed++;
        for (int i = 0; i < 3; i++) begin
            pipe_valid = 1; pipe_rd = 5'd2; pipe_data = 32'h22;
            lu_valid = 1; lu_data = 32'(i);
            lu_rd = (i == 0) ? 5'd7 : (i == 1) ? 5'd9 : 5'd20;
            step();
        end
        total++; if (fifo_count !== 3'd3) $display("FAIL ar_fill got %0d want 3", fifo_count); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (fifo_count !== 3'd0) $display("FAIL ar_count got %0d want 0", fifo_count); else passed++;
        total++; if (busy !== 32'h0) $display("FAIL ar_busy_clr got %h want 0", busy); else passed++;
        total++; if (wb_we !== 1'b0) $display("FAIL ar_we got %0b want 0", wb_we); else passed++;
        pipe_valid = 0; lu_valid = 0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (wb_we !== 1'b0 || fifo_count !== 3'd0)
                $display("FAIL ar_stale%0d got we=%0b count=%0d want 0/0", i, wb_we, fifo_count);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_pipe();
        test_bypass();
        test_backpressure();
        test_rd0();
        test_set_wins();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that owns the single write port of the integer register file. It merges two sources into one registered write per cycle: the in-order pipeline writeback, which is never stalled, and a long-latency unit (divider/load miss) that completes out of order through a valid/ready handshake. Long-latency results are buffered in a small FIFO and drain in cycles the pipeline leaves free. A per-register busy scoreboard tells the decode/read side which registers still await a long-latency result.

## Interface
Parameters:
- DEPTH, 4, long-latency FIFO entries (power of two, ≥2)
- XLEN, 32, data width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- pipe_valid  in  1  pipeline writeback request this cycle (always accepted)
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  XLEN  pipeline result
- lu_issue  in  1  long-latency op issued this cycle; reserve lu_issue_rd
- lu_issue_rd  in  5  destination reserved by the issue
- lu_valid  in  1  long-latency result offered
- lu_rd  in  5  long-latency destination
- lu_data  in  XLEN  long-latency result
- lu_ready  out  1  arbiter accepts lu result this cycle
- wb_we  out  1  register-file write enable (registered)
- wb_rd  out  5  register-file write address (registered)
- wb_data  out  XLEN  register-file write data (registered)
- busy  out  32  scoreboard, bit n = register n awaits a long-latency write
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Reset: wb_we=0, wb_rd=0, wb_data=0, busy=0, fifo_count=0, FIFO pointers 0; lu_ready=1 after reset.
- lu_ready = (fifo_count != DEPTH); purely combinational from count. Handshake: lu result transfers when lu_valid && lu_ready; lu side holds lu_rd/lu_data stable while lu_valid && !lu_ready.
- Per-cycle selection for the output register, priority order:
  1. pipe_valid=1: write pipe_rd/pipe_data.
  2. else FIFO non-empty: pop head, write it.
  3. else lu transfer this cycle: bypass straight to output, not enqueued.
  4. else wb_we=0 (wb_rd/wb_data hold previous values).
- An lu transfer not consumed by the bypass is pushed at the tail. Push and pop in the same cycle leave fifo_count unchanged.
- FIFO drains in arrival order; no reordering among lu results.
- Destination 0: any selected write with rd=0 yields wb_we=0 but still consumes the entry (pop/bypass occurs).
- Scoreboard: on lu_issue with lu_issue_rd≠0, set busy[lu_issue_rd]. When an lu-sourced entry (pop or bypass) is selected, clear busy[rd] at the same edge the output register loads. Set and clear of the same bit in one cycle: set wins. Pipeline writes never touch busy.
- No WAW ordering enforcement between sources; decode uses busy to prevent it.

## Timing
- Pipeline path: latency 1 cycle (request at edge N, wb_we visible after edge N+1), every cycle, no backpressure.
- lu path: 1 cycle when bypassed; otherwise 1 cycle after the first cycle with pipe_valid=0 that finds the entry at the FIFO head.
- Sustained pipe_valid=1 starves the FIFO; lu_ready drops once DEPTH entries are held and recovers the cycle after the first pop.
- Reset asserted mid-operation: all buffered entries and busy bits are discarded immediately (asynchronous); no write is emitted for them.

## Configuration
- WB_SCOREBOARD_EN defined: busy register, set/clear logic and lu_issue/lu_issue_rd as described.
- Not defined: busy tied to 32'b0, lu_issue/lu_issue_rd ignored; all other behaviour identical.

## Test plan
- Reset then pipe_valid=1, pipe_rd=5, pipe_data=0xDEADBEEF -> next cycle wb_we=1, wb_rd=5, wb_data=0xDEADBEEF; busy=0, lu_ready=1.
- lu_issue rd=7; 3 cycles later lu_valid rd=7 data=0x12345678 with pipe idle, FIFO empty -> bypass, wb_we=1 wb_rd=7 next cycle; busy[7] 1→0 at that edge; fifo_count stays 0.
- pipe_valid held 1 for 10 cycles while lu offers 5 results (DEPTH=4) -> 4 accepted, lu_ready=0 with fifo_count=4; after pipe_valid drops, entries written in arrival order, one per cycle, then 5th accepted.
- lu result with rd=0 -> wb_we stays 0, entry consumed, fifo_count unchanged/decremented accordingly.
- lu_issue rd=9 in the same cycle an lu result for rd=9 is written -> busy[9]=1 afterwards.
- Reset asserted with fifo_count=3 and busy=0x0000_0280 -> immediately fifo_count=0, busy=0, wb_we=0; no stale writes after release.
